// File: rtl/dff_pipe.sv
// dff_pipe: parametrised multi-stage registered delay line with valid tracking.
//
// A WIDTH-bit data word and its valid bit travel through DEPTH register stages.
// The pipe advances only while en is high, is cleared synchronously by flush
// (flush wins over en), and keeps a registered count of valid stages in occ.
// Data is registered every enabled cycle whether or not d_vld is set; the
// valid bit only qualifies it.
//
// Parameters:
//   WIDTH     - data word width in bits (>= 1)
//   DEPTH     - number of stages, i.e. latency in enabled cycles (>= 1)
//   RESET_VAL - data value loaded into every stage on reset and on flush
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   en     in   advance enable
//   flush  in   synchronous clear of all stages (overrides en)
//   d      in   input data word
//   d_vld  in   input data valid
//   q      out  data of the last stage
//   q_vld  out  valid bit of the last stage
//   occ    out  number of stages currently holding valid data
//
// Optional build macro:
//   DFF_PIPE_ASSERT_EN - compiles embedded assertions and covers for latency,
//                        stall, occupancy bound and flush behaviour. Without it
//                        no assertion code is compiled and behaviour is the same.

module dff_pipe #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [OCC_W-1:0] occ
);

  // Elaboration-time parameter sanity.
  if (WIDTH < 1) begin : g_bad_width
    $error("dff_pipe: WIDTH must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe: DEPTH must be >= 1");
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Incremental occupancy: one word may enter and one may leave per enabled
  // cycle. The leaving word is the last stage's valid bit before the shift.
  always_comb begin
    occ_d = occ_q;
    if (en) begin
      occ_d = occ_q + OCC_W'(d_vld) - OCC_W'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= RESET_VAL;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= RESET_VAL;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else if (en) begin
      data_q[0] <= d;
      vld_q[0]  <= d_vld;
      for (int i = 1; i < int'(DEPTH); i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
      occ_q <= occ_d;
    end
  end

  // Outputs come straight from flops; no input-to-output combinational path.
  assign q     = data_q[DEPTH-1];
  assign q_vld = vld_q[DEPTH-1];
  assign occ   = occ_q;

`ifdef DFF_PIPE_ASSERT_EN

  // (a) After DEPTH consecutive enabled cycles the output is the input from
  // DEPTH cycles earlier.
  property p_latency;
    @(posedge clk) disable iff (!reset || flush)
      en [*DEPTH] |=> (q == $past(d, DEPTH)) && (q_vld == $past(d_vld, DEPTH));
  endproperty
  a_latency: assert property (p_latency)
    else $error("dff_pipe a_latency: q/q_vld differ from input DEPTH enabled cycles ago");

  // (b) A stalled cycle leaves every output unchanged.
  property p_stall;
    @(posedge clk) disable iff (!reset || flush)
      !en |=> $stable(q) && $stable(q_vld) && $stable(occ);
  endproperty
  a_stall: assert property (p_stall)
    else $error("dff_pipe a_stall: outputs changed during stall");

  // (c) Occupancy can never exceed the number of stages.
  property p_bound;
    @(posedge clk) disable iff (!reset || flush)
      occ <= OCC_W'(DEPTH);
  endproperty
  a_bound: assert property (p_bound)
    else $error("dff_pipe a_bound: occ exceeds DEPTH");

  // (d) flush is the trigger of this property, so only reset may disable it;
  // disabling on flush would make it vacuous.
  property p_flush;
    @(posedge clk) disable iff (!reset)
      flush |=> (occ == '0) && !q_vld && (q == RESET_VAL);
  endproperty
  a_flush: assert property (p_flush)
    else $error("dff_pipe a_flush: pipe not empty after flush");

  c_full: cover property (
    @(posedge clk) disable iff (!reset || flush) occ == OCC_W'(DEPTH));

  c_stall_full: cover property (
    @(posedge clk) disable iff (!reset || flush) (occ == OCC_W'(DEPTH)) && !en);

`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe with WIDTH=8, DEPTH=4, RESET_VAL=0.
// A table of per-cycle {inputs, expected outputs} records is applied one
// clock at a time; reset behaviour is exercised by hand-written sequences.

module tb_dff_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_vld;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic [OCC_W-1:0] occ;

  int checks;
  int errors;

  typedef struct {
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_vld;
    logic [WIDTH-1:0] exp_q;
    logic             exp_vld;
    logic [OCC_W-1:0] exp_occ;
  } vec_t;

  vec_t vecs[$];

  dff_pipe #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .flush(flush),
    .d    (d),
    .d_vld(d_vld),
    .q    (q),
    .q_vld(q_vld),
    .occ  (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic e, input logic f, input logic [7:0] dd, input logic v,
                     input logic [7:0] eq, input logic ev, input logic [2:0] eo);
    vec_t t;
    t.en = e; t.flush = f; t.d = dd; t.d_vld = v;
    t.exp_q = eq; t.exp_vld = ev; t.exp_occ = eo;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] eq, input logic ev,
                       input logic [2:0] eo);
    checks++;
    if (q !== eq || q_vld !== ev || occ !== eo) begin
      errors++;
      $display("FAIL %s: got q=%h q_vld=%b occ=%0d, expected q=%h q_vld=%b occ=%0d",
               name, q, q_vld, occ, eq, ev, eo);
    end
  endtask

  task automatic step(input logic e, input logic f, input logic [7:0] dd, input logic v);
    en = e; flush = f; d = dd; d_vld = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Shift, stream of 1..5, then drain.
    add(1, 0, 8'h01, 1, 8'h00, 0, 3'd1);  // 0
    add(1, 0, 8'h02, 1, 8'h00, 0, 3'd2);
    add(1, 0, 8'h03, 1, 8'h00, 0, 3'd3);
    add(1, 0, 8'h04, 1, 8'h01, 1, 3'd4);
    add(1, 0, 8'h05, 1, 8'h02, 1, 3'd4);
    add(1, 0, 8'h00, 0, 8'h03, 1, 3'd3);  // 5
    add(1, 0, 8'h00, 0, 8'h04, 1, 3'd2);
    add(1, 0, 8'h00, 0, 8'h05, 1, 3'd1);
    add(1, 0, 8'h00, 0, 8'h00, 0, 3'd0);
    // Stall for 3 cycles after the second word enters; ignored inputs during stall.
    add(1, 0, 8'h11, 1, 8'h00, 0, 3'd1);
    add(1, 0, 8'h12, 1, 8'h00, 0, 3'd2);  // 10
    add(0, 0, 8'hEE, 1, 8'h00, 0, 3'd2);
    add(0, 0, 8'hEE, 1, 8'h00, 0, 3'd2);
    add(0, 0, 8'hEE, 1, 8'h00, 0, 3'd2);
    add(1, 0, 8'h13, 1, 8'h00, 0, 3'd3);
    add(1, 0, 8'h14, 1, 8'h11, 1, 3'd4);  // 15
    add(1, 0, 8'h00, 0, 8'h12, 1, 3'd3);
    add(1, 0, 8'h15, 1, 8'h13, 1, 3'd3);
    add(1, 0, 8'h16, 1, 8'h14, 1, 3'd3);
    add(1, 0, 8'h17, 1, 8'h00, 0, 3'd3);
    add(1, 0, 8'h18, 1, 8'h15, 1, 3'd4);  // 20: full
    // Flush with en and a valid word; 8'hAA must never appear.
    add(1, 1, 8'hAA, 1, 8'h00, 0, 3'd0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 3'd0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 3'd0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 3'd0);
    // Alternating valid; occ settles at 2.
    add(1, 0, 8'h31, 1, 8'h00, 0, 3'd1);  // 25
    add(1, 0, 8'h32, 0, 8'h00, 0, 3'd1);
    add(1, 0, 8'h33, 1, 8'h00, 0, 3'd2);
    add(1, 0, 8'h34, 0, 8'h31, 1, 3'd2);
    add(1, 0, 8'h35, 1, 8'h32, 0, 3'd2);
    add(1, 0, 8'h36, 0, 8'h33, 1, 3'd2);  // 30
    add(1, 0, 8'h37, 1, 8'h34, 0, 3'd2);
    add(1, 0, 8'h38, 1, 8'h35, 1, 3'd3);

    // Reset held for two cycles with busy inputs.
    reset = 1'b0; en = 1'b1; flush = 1'b0; d = 8'hFF; d_vld = 1'b1;
    #1;
    check("reset_initial", 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", 8'h00, 1'b0, 3'd0);
    end
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].flush, vecs[i].d, vecs[i].d_vld);
      check($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_vld, vecs[i].exp_occ);
    end

    // Async reset mid-cycle with occ=3: outputs clear before any clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_mid_cycle", 8'h00, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // First valid word after release appears exactly 4 enabled cycles later.
    step(1, 0, 8'h5A, 1);
    check("post_reset_c1", 8'h00, 1'b0, 3'd1);
    step(0, 0, 8'h77, 1);
    check("post_reset_stall", 8'h00, 1'b0, 3'd1);
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    check("post_reset_c3", 8'h00, 1'b0, 3'd1);
    step(1, 0, 8'h00, 0);
    check("post_reset_c4", 8'h5A, 1'b1, 3'd1);
    step(1, 0, 8'h00, 0);
    check("post_reset_drain", 8'h00, 1'b0, 3'd0);

    // Flush overrides a stall.
    step(1, 0, 8'h61, 1);
    step(1, 0, 8'h62, 1);
    check("pre_flush_stall", 8'h00, 1'b0, 3'd2);
    step(0, 1, 8'h63, 1);
    check("flush_during_stall", 8'h00, 1'b0, 3'd0);
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    check("flush_stall_drained", 8'h00, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
